// File: rtl/dual_core_pmem_arbiter.sv
// ============================================================================
//  Module   : dual_core_pmem_arbiter
//  Purpose  : Round-robin owner of the single psum-memory write port shared
//             by two core controllers. A granted core streams a fixed-length
//             burst into its own address region. A two-core barrier releases
//             the SFP partial-sum exchange once both cores have finished.
//  Ports    : clk, reset (async, active-low)
//             req0/req0_valid/req0_data -> gnt0, done0   (core0)
//             req1/req1_valid/req1_data -> gnt1, done1   (core1)
//             pmem_wr, pmem_add, pmem_din                (pmem write port)
//             sum_rdy0, sum_rdy1 -> sum_swap             (barrier)
//             busy                                       (FSM not IDLE)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_core_pmem_arbiter #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              gnt1,
    output logic              done1,
    output logic              pmem_wr,
    output logic [ADDR_W-1:0] pmem_add,
    output logic [DATA_W-1:0] pmem_din,
    input  logic              sum_rdy0,
    input  logic              sum_rdy1,
    output logic              sum_swap,
    output logic              busy
);

    localparam int                BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] CORE1_BASE = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [BEAT_W-1:0]   beat, beat_next;
    logic                last_grant, last_grant_next;
    logic                wr_next, done0_next, done1_next;
    logic [ADDR_W-1:0]   add_next;
    logic [DATA_W-1:0]   din_next;
    logic                f0, f1;
    logic                rdy0_eff, rdy1_eff, swap_now;

    // ------------------------------------------------------------------
    // Arbiter next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        beat_next       = beat;
        last_grant_next = last_grant;
        wr_next         = 1'b0;
        add_next        = pmem_add;
        din_next        = pmem_din;
        done0_next      = 1'b0;
        done1_next      = 1'b0;

        case (state)
            IDLE: begin
                // A done pulse still being visible means the burst ended on the
                // previous edge; holding off one more cycle guarantees the
                // mandatory idle cycle between bursts.
                if (!(done0 || done1)) begin
                    // last_grant==1 means core1 was served last, so core0 wins a tie.
                    if (req0 && (!req1 || last_grant)) begin
                        state_next = GRANT0;
                    end else if (req1) begin
                        state_next = GRANT1;
                    end
                end
            end

            GRANT0: begin
                if (req0_valid) begin
                    wr_next  = 1'b1;
                    add_next = ADDR_W'(beat);
                    din_next = req0_data;
                    if (beat == LAST_BEAT) begin
                        beat_next       = '0;
                        done0_next      = 1'b1;
                        last_grant_next = 1'b0;
                        state_next      = IDLE;
                    end else begin
                        beat_next = beat + BEAT_W'(1);
                    end
                end
            end

            GRANT1: begin
                if (req1_valid) begin
                    wr_next  = 1'b1;
                    add_next = CORE1_BASE + ADDR_W'(beat);
                    din_next = req1_data;
                    if (beat == LAST_BEAT) begin
                        beat_next       = '0;
                        done1_next      = 1'b1;
                        last_grant_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        beat_next = beat + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat       <= '0;
            last_grant <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            pmem_wr    <= 1'b0;
            pmem_add   <= '0;
            pmem_din   <= '0;
        end else begin
            state      <= state_next;
            beat       <= beat_next;
            last_grant <= last_grant_next;
            gnt0       <= (state_next == GRANT0);
            gnt1       <= (state_next == GRANT1);
            done0      <= done0_next;
            done1      <= done1_next;
            busy       <= (state_next != IDLE);
            pmem_wr    <= wr_next;
            pmem_add   <= add_next;
            pmem_din   <= din_next;
        end
    end

    // ------------------------------------------------------------------
    // Barrier: a ready seen this cycle counts immediately, so the swap pulse
    // follows the edge that samples the second ready. The flags clear on
    // that edge; a ready arriving during the swap cycle re-arms its flag.
    // ------------------------------------------------------------------
    assign rdy0_eff = f0 | sum_rdy0;
    assign rdy1_eff = f1 | sum_rdy1;
    assign swap_now = rdy0_eff & rdy1_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f0       <= 1'b0;
            f1       <= 1'b0;
            sum_swap <= 1'b0;
        end else begin
            sum_swap <= swap_now;
            f0       <= swap_now ? 1'b0 : rdy0_eff;
            f1       <= swap_now ? 1'b0 : rdy1_eff;
        end
    end

endmodule

`default_nettype wire

// File: doc/dual_core_pmem_arbiter.md
Name: dual_core_pmem_arbiter

Overview:
Shares the single psum memory (pmem) write port between the two core controllers of the dual-core attention datapath. Each core requests a fixed-length burst of pmem writes. The block grants the port round-robin, generates the pmem write strobe and address, and muxes the write data. It also provides a two-core barrier that releases the SFP partial-sum exchange only when both cores have finished accumulation.

Parameters:
DATA_W, 128, width of one pmem write word
ADDR_W, 4, pmem address width (depth 2^ADDR_W)
BURST_LEN, 8, beats per granted burst; core0 region is 0..BURST_LEN-1, core1 region is BURST_LEN..2*BURST_LEN-1; 2*BURST_LEN must be <= 2^ADDR_W

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
req0  in  1  core0 requests a burst (level)
req0_valid  in  1  core0 beat valid while granted
req0_data  in  DATA_W  core0 write word
gnt0  out  1  core0 owns the pmem port
done0  out  1  one-cycle pulse on core0 burst completion
req1, req1_valid, req1_data, gnt1, done1  as core0, for core1
pmem_wr  out  1  pmem write enable
pmem_add  out  ADDR_W  pmem write address
pmem_din  out  DATA_W  pmem write data
sum_rdy0  in  1  core0 SFP accumulation done (pulse or level)
sum_rdy1  in  1  core1 SFP accumulation done
sum_swap  out  1  one-cycle pulse: both cores may exchange sums
busy  out  1  arbiter is not IDLE

Behaviour:
- All outputs are registered. When reset is low, every output is 0, state=IDLE, beat=0, last_grant=1 (core0 wins the first tie), and barrier flags f0=f1=0.
- FSM states: IDLE, GRANT0, GRANT1. busy=1 in GRANT0/GRANT1.
- IDLE, req0 only: go to GRANT0. req1 only: go to GRANT1. Both asserted: grant the core that is not last_grant. gntN rises on the clock edge after reqN is sampled, so grant latency is 1 cycle.
- GRANTN: gntN=1 and the other gnt=0. Each cycle with reqN_valid=1, on the next edge:
  - pmem_wr=1
  - pmem_add = N*BURST_LEN + beat
  - pmem_din = reqN_data
  - beat increments
- Valid-to-write latency is 1 cycle. A cycle with reqN_valid=0 is a gap: pmem_wr=0 and beat holds.
- Last beat (beat==BURST_LEN-1 with valid): on the same edge that drives the last pmem_wr, doneN=1 for one cycle, gntN falls, beat returns to 0, last_grant=N, and state returns to IDLE.
- IDLE always spends at least one cycle before the next grant. The next grant therefore appears 2 cycles after doneN at the earliest.
- Once granted, reqN is ignored; a burst ends only by beat count. The non-granted core's valid and data are ignored. A request held high during the other core's burst is served next (no starvation).
- pmem_din holds its last value when pmem_wr=0.
- Barrier: f0 is set by sum_rdy0 and f1 by sum_rdy1 (sticky).
  - When f0&f1 (including both set in the same cycle), sum_swap=1 on the next edge for exactly one cycle, and f0 and f1 clear on that edge.
  - A sum_rdyN asserted in the swap cycle sets fN for the next round; set wins over clear.
  - Barrier operation is independent of the arbiter FSM.
- Reset asserted mid-burst: immediate return to the reset values. No done pulse is issued, and the partial burst is not resumed.

Test Plan:
- Single core0 burst: req0=1, 8 consecutive valid beats with data 0x10..0x17 -> gnt0 high 1 cycle after req0; pmem_wr on addresses 0..7 with the matching data; done0 pulses with the write to address 7; gnt0=0 next cycle.
- Simultaneous req0=req1=1 after reset -> core0 granted first (addresses 0..7), then core1 (addresses 8..15), gnt1 2 cycles after done0; repeating both -> strict alternation 0,1,0,1.
- Core1 burst with valid gaps (valid pattern 1,0,0,1,...) -> no pmem_wr in gap cycles; addresses 8..15 in order with no skips; done1 only after the 8th valid beat.
- Barrier: sum_rdy0 at cycle 5, sum_rdy1 at cycle 20 -> single sum_swap pulse at cycle 21. Both asserted at cycle 30 -> swap at cycle 31. sum_rdy0 asserted in the swap cycle -> f0 remains set, and there is no swap until sum_rdy1.
- Reset (low) asserted after 3 beats of a core0 burst -> gnt0, pmem_wr, done0, busy and sum_swap all 0 immediately. After release, core0's first write goes to address 0.
- Non-granted core0 drives req0_valid=1 with data 0xFF during a core1 burst -> pmem_din never shows 0xFF; only core1 data is written to addresses 8..15.
